// File: rtl/mem_stage.sv
// MEM stage of the 16-bit five-stage CPU: data-memory access over req/ack with a
// bounded WAIT, store-data forwarding from MEM/WB, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_vld,
    input  logic [15:0] ex_mem_alu_res,
    input  logic [15:0] ex_mem_rt_data,
    input  logic [3:0]  ex_mem_rt,
    input  logic [3:0]  ex_mem_rd,
    input  logic        ex_mem_memrd,
    input  logic        ex_mem_memwr,
    input  logic        ex_mem_regwr,
    input  logic        ex_mem_hlt,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        mem_wb_vld,
    output logic        mem_wb_regwr,
    output logic        mem_wb_hlt,
    output logic [3:0]  mem_wb_rd,
    output logic [15:0] mem_wb_data
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        err_q;
    logic        rst_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        wb_vld_q;
    logic        wb_regwr_q;
    logic        wb_hlt_q;
    logic [3:0]  wb_rd_q;
    logic [15:0] wb_data_q;

    logic        live;
    logic        vld_eff;
    logic        mem_op;
    logic        fwd;
    logic [15:0] wdata_d;
    logic        in_wait;
    logic        timeout_cycle;
    logic        is_load;
    logic [15:0] result_d;

    // Requests are suppressed in the reset cycle and the cycle right after it.
    assign live     = ~rst & ~rst_q;
    assign vld_eff  = ex_mem_vld & live;
    assign mem_op   = vld_eff & (ex_mem_memrd | ex_mem_memwr);
    assign is_load  = ex_mem_memrd & ~ex_mem_memwr;

    assign fwd      = ex_mem_memwr & wb_vld_q & wb_regwr_q
                    & (ex_mem_rt != 4'd0) & (wb_rd_q == ex_mem_rt);
    assign wdata_d  = fwd ? wb_data_q : ex_mem_rt_data;

    assign in_wait  = (state_q == WAIT) & ~rst;
    assign dmem_req = in_wait | ((state_q == IDLE) & mem_op);
    assign dmem_we    = in_wait ? we_q    : ex_mem_memwr;
    assign dmem_addr  = in_wait ? addr_q  : ex_mem_alu_res;
    assign dmem_wdata = in_wait ? wdata_q : wdata_d;

    assign timeout_cycle = in_wait & ~dmem_ack & (cnt_q == CNT_LAST);
    assign mem_stall     = dmem_req & ~dmem_ack & ~timeout_cycle;

    assign result_d = timeout_cycle          ? 16'h0000   :
                      (dmem_req & is_load)   ? dmem_rdata :
                                               ex_mem_alu_res;

    assign mem_err      = err_q;
    assign mem_wb_vld   = wb_vld_q;
    assign mem_wb_regwr = wb_regwr_q;
    assign mem_wb_hlt   = wb_hlt_q;
    assign mem_wb_rd    = wb_rd_q;
    assign mem_wb_data  = wb_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            err_q      <= 1'b0;
            rst_q      <= 1'b1;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            we_q       <= 1'b0;
            wb_vld_q   <= 1'b0;
            wb_regwr_q <= 1'b0;
            wb_hlt_q   <= 1'b0;
            wb_rd_q    <= 4'd0;
            wb_data_q  <= 16'h0000;
        end else begin
            rst_q <= 1'b0;

            // Bubbles keep rd/data so the forwarding source stays stable.
            if (mem_stall || !vld_eff) begin
                wb_vld_q   <= 1'b0;
                wb_regwr_q <= 1'b0;
                wb_hlt_q   <= 1'b0;
            end else begin
                wb_vld_q   <= 1'b1;
                wb_regwr_q <= ex_mem_regwr & ~ex_mem_memwr;
                wb_hlt_q   <= ex_mem_hlt;
                wb_rd_q    <= ex_mem_rd;
                wb_data_q  <= result_d;
            end

            case (state_q)
                IDLE: begin
                    if (mem_op && !dmem_ack) begin
                        state_q <= WAIT;
                        cnt_q   <= 4'd0;
                        addr_q  <= ex_mem_alu_res;
                        we_q    <= ex_mem_memwr;
                        wdata_q <= wdata_d;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state_q <= IDLE;
                    end else if (timeout_cycle) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: passthrough, zero-wait and multi-cycle accesses,
// store forwarding, timeout, reset during WAIT and ignored acks.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_vld;
    logic [15:0] ex_mem_alu_res;
    logic [15:0] ex_mem_rt_data;
    logic [3:0]  ex_mem_rt;
    logic [3:0]  ex_mem_rd;
    logic        ex_mem_memrd;
    logic        ex_mem_memwr;
    logic        ex_mem_regwr;
    logic        ex_mem_hlt;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        mem_err;
    logic        mem_wb_vld;
    logic        mem_wb_regwr;
    logic        mem_wb_hlt;
    logic [3:0]  mem_wb_rd;
    logic [15:0] mem_wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_vld(ex_mem_vld), .ex_mem_alu_res(ex_mem_alu_res),
        .ex_mem_rt_data(ex_mem_rt_data), .ex_mem_rt(ex_mem_rt), .ex_mem_rd(ex_mem_rd),
        .ex_mem_memrd(ex_mem_memrd), .ex_mem_memwr(ex_mem_memwr),
        .ex_mem_regwr(ex_mem_regwr), .ex_mem_hlt(ex_mem_hlt),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .mem_err(mem_err),
        .mem_wb_vld(mem_wb_vld), .mem_wb_regwr(mem_wb_regwr), .mem_wb_hlt(mem_wb_hlt),
        .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            $display("ok   %s: %h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ex_mem_vld = 0; ex_mem_alu_res = 0; ex_mem_rt_data = 0; ex_mem_rt = 0;
        ex_mem_rd = 0; ex_mem_memrd = 0; ex_mem_memwr = 0; ex_mem_regwr = 0;
        ex_mem_hlt = 0; dmem_rdata = 0; dmem_ack = 0;
    endtask

    task automatic set_instr(input logic rd_f, input logic wr_f, input logic rw,
                             input logic [15:0] alu, input logic [3:0] rd,
                             input logic [3:0] rt, input logic [15:0] rtd);
        ex_mem_vld = 1; ex_mem_memrd = rd_f; ex_mem_memwr = wr_f; ex_mem_regwr = rw;
        ex_mem_alu_res = alu; ex_mem_rd = rd; ex_mem_rt = rt; ex_mem_rt_data = rtd;
        ex_mem_hlt = 0;
    endtask

    int  req_cnt;
    int  stall_cnt;
    logic done;

    initial begin
        clear_in();
        rst = 1;
        set_instr(1, 0, 1, 16'h0040, 4'd1, 4'd0, 16'h0);
        tick();
        #2 chk("req_in_reset", dmem_req, 0);
        tick();
        rst = 0;
        #2;
        chk("req_after_reset", dmem_req, 0);
        chk("rst_wb_vld", mem_wb_vld, 0);
        chk("rst_wb_regwr", mem_wb_regwr, 0);
        chk("rst_wb_hlt", mem_wb_hlt, 0);
        chk("rst_wb_rd", mem_wb_rd, 0);
        chk("rst_wb_data", mem_wb_data, 0);
        chk("rst_err", mem_err, 0);
        clear_in();
        tick();

        // ALU passthrough
        set_instr(0, 0, 1, 16'h1234, 4'd5, 4'd0, 16'h0);
        ex_mem_hlt = 1;
        #2;
        chk("alu_stall", mem_stall, 0);
        chk("alu_req", dmem_req, 0);
        tick();
        chk("alu_data", mem_wb_data, 16'h1234);
        chk("alu_rd", mem_wb_rd, 5);
        chk("alu_regwr", mem_wb_regwr, 1);
        chk("alu_vld", mem_wb_vld, 1);
        chk("alu_hlt", mem_wb_hlt, 1);

        // Zero-wait load followed back-to-back by a second one
        set_instr(1, 0, 1, 16'h0040, 4'd6, 4'd0, 16'h0);
        dmem_ack = 1; dmem_rdata = 16'hBEEF;
        #2;
        chk("zw_req", dmem_req, 1);
        chk("zw_we", dmem_we, 0);
        chk("zw_addr", dmem_addr, 16'h0040);
        chk("zw_stall", mem_stall, 0);
        tick();
        chk("zw_data", mem_wb_data, 16'hBEEF);
        chk("zw_rd", mem_wb_rd, 6);
        chk("zw_vld", mem_wb_vld, 1);
        set_instr(1, 0, 1, 16'h0042, 4'd8, 4'd0, 16'h0);
        dmem_ack = 1; dmem_rdata = 16'h1111;
        #2 chk("b2b_addr", dmem_addr, 16'h0042);
        tick();
        chk("b2b_data", mem_wb_data, 16'h1111);
        chk("b2b_rd", mem_wb_rd, 8);

        // Producer of r3 = 00AA, then a 3-cycle store that forwards it
        clear_in();
        set_instr(0, 0, 1, 16'h00AA, 4'd3, 4'd0, 16'h0);
        tick();
        set_instr(0, 1, 0, 16'h0010, 4'd0, 4'd3, 16'h0000);
        stall_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            dmem_ack = (c == 2);
            #2;
            chk($sformatf("fwd_wdata_c%0d", c), dmem_wdata, 16'h00AA);
            chk($sformatf("fwd_addr_c%0d", c), dmem_addr, 16'h0010);
            chk($sformatf("fwd_we_c%0d", c), dmem_we, 1);
            if (mem_stall) stall_cnt++;
            tick();
            chk($sformatf("fwd_wb_vld_c%0d", c), mem_wb_vld, (c == 2) ? 1 : 0);
        end
        chk("fwd_stall_cycles", stall_cnt, 2);
        chk("fwd_wb_regwr", mem_wb_regwr, 0);
        chk("fwd_wb_data", mem_wb_data, 16'h0010);

        // rt=0 store (with both flags) after a write to r0: no forwarding
        clear_in();
        set_instr(0, 0, 1, 16'h5555, 4'd0, 4'd0, 16'h0);
        tick();
        set_instr(1, 1, 1, 16'h0020, 4'd4, 4'd0, 16'h1357);
        dmem_ack = 1;
        #2;
        chk("r0_wdata", dmem_wdata, 16'h1357);
        chk("both_we", dmem_we, 1);
        tick();
        chk("both_regwr", mem_wb_regwr, 0);
        chk("both_vld", mem_wb_vld, 1);

        // Timeout on a load that is never acknowledged
        clear_in();
        set_instr(1, 0, 1, 16'h0080, 4'd7, 4'd0, 16'h0);
        req_cnt = 0; stall_cnt = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #2;
            if (dmem_req) req_cnt++;
            if (mem_stall) stall_cnt++;
            tick();
            if (mem_wb_vld) done = 1;
        end
        chk("to_completed", done, 1);
        chk("to_req_cycles", req_cnt, 16);
        chk("to_stall_cycles", stall_cnt, 15);
        chk("to_err", mem_err, 1);
        chk("to_data", mem_wb_data, 16'h0000);
        chk("to_regwr", mem_wb_regwr, 1);
        chk("to_rd", mem_wb_rd, 7);
        clear_in();
        #2 chk("to_req_after", dmem_req, 0);
        tick();
        chk("to_err_sticky", mem_err, 1);

        // Reset on the second WAIT cycle abandons the access
        set_instr(1, 0, 1, 16'h00C0, 4'd9, 4'd0, 16'h0);
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        #2;
        chk("rw_req", dmem_req, 0);
        chk("rw_stall", mem_stall, 0);
        chk("rw_wb_vld", mem_wb_vld, 0);
        chk("rw_wb_data", mem_wb_data, 0);
        chk("rw_wb_rd", mem_wb_rd, 0);
        chk("rw_err", mem_err, 0);
        dmem_ack = 1; dmem_rdata = 16'hABCD;
        tick();
        chk("rw_late_ack_vld", mem_wb_vld, 0);
        chk("rw_late_ack_data", mem_wb_data, 0);

        // Ack with no request is ignored; a following load must still wait
        clear_in();
        dmem_ack = 1; dmem_rdata = 16'hFFFF;
        tick();
        chk("ign_wb_vld", mem_wb_vld, 0);
        dmem_ack = 0;
        set_instr(1, 0, 1, 16'h0100, 4'd2, 4'd0, 16'h0);
        #2 chk("ign_then_stall", mem_stall, 1);
        tick();
        dmem_ack = 1; dmem_rdata = 16'h7777;
        #2 chk("ign_wait_addr", dmem_addr, 16'h0100);
        tick();
        chk("ign_load_data", mem_wb_data, 16'h7777);
        clear_in();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
